// File: rtl/tuner_pkg.sv
//------------------------------------------------------------------------------
// tuner_pkg : shared widths and FSM state encoding for the tuner sweep block
// Revision  : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package tuner_pkg;

  localparam int FSZ_DEF        = 31;
  localparam int DSZ_DEF        = 1;
  localparam int CSZ_DEF        = 16;
  localparam int WSZ_DEF        = 24;
  localparam int SETTLE_CYC_DEF = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_DWELL  = 3'd2,
    S_STEP   = 3'd3,
    S_DONE   = 3'd4
  } state_e;

endpackage

`default_nettype wire

// File: rtl/sweep_timer.sv
//------------------------------------------------------------------------------
// sweep_timer : loadable down-counter with zero flag, shared by SETTLE/DWELL
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sweep_timer
  import tuner_pkg::*;
#(
  parameter int WIDTH = WSZ_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/tuner_sweep_ctrl.sv
//------------------------------------------------------------------------------
// tuner_sweep_ctrl : stepped LO frequency sweep with settle/dwell sequencing.
// Optional continuous looping via macro TUNER_SWEEP_LOOP_EN.  Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tuner_sweep_ctrl
  import tuner_pkg::*;
#(
  parameter int FSZ        = FSZ_DEF,
  parameter int CSZ        = CSZ_DEF,
  parameter int WSZ        = WSZ_DEF,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           abort,
  input  logic [FSZ-1:0] cfg_start_freq,
  input  logic [FSZ-1:0] cfg_step,
  input  logic           cfg_dir,
  input  logic [CSZ-1:0] cfg_count,
  input  logic [WSZ-1:0] cfg_dwell,
`ifdef TUNER_SWEEP_LOOP_EN
  input  logic           cfg_loop,
`endif
  output logic           busy,
  output logic           done,
  output logic [FSZ-1:0] lo_freq,
  output logic           lo_dir,
  output logic           iq_valid,
  output logic [CSZ-1:0] hop_idx,
  output logic           hop_strobe
);

  localparam logic [WSZ-1:0] SETTLE_LOAD = WSZ'(SETTLE_CYC - 1);

  state_e         state_q, state_d;
  logic [FSZ-1:0] start_freq_q, start_freq_d;
  logic [FSZ-1:0] step_q, step_d;
  logic [CSZ-1:0] last_idx_q, last_idx_d;
  logic [WSZ-1:0] dwell_load_q, dwell_load_d;
  logic           loop_q, loop_d;
  logic [FSZ-1:0] lo_freq_q, lo_freq_d;
  logic           lo_dir_q, lo_dir_d;
  logic [CSZ-1:0] hop_idx_q, hop_idx_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           iq_valid_q, iq_valid_d;
  logic           hop_strobe_q, hop_strobe_d;

  logic           tmr_load;
  logic [WSZ-1:0] tmr_load_val;
  logic           tmr_dec;
  logic           tmr_zero;

  sweep_timer #(
    .WIDTH (WSZ)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d      = state_q;
    start_freq_d = start_freq_q;
    step_d       = step_q;
    last_idx_d   = last_idx_q;
    dwell_load_d = dwell_load_q;
    loop_d       = loop_q;
    lo_freq_d    = lo_freq_q;
    lo_dir_d     = lo_dir_q;
    hop_idx_d    = hop_idx_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    iq_valid_d   = 1'b0;
    hop_strobe_d = 1'b0;
    tmr_load     = 1'b0;
    tmr_load_val = SETTLE_LOAD;
    tmr_dec      = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (start && !abort) begin
          start_freq_d = cfg_start_freq;
          step_d       = cfg_step;
          // Zero count/dwell are treated as one hop / one cycle.
          last_idx_d   = (cfg_count == '0) ? '0 : cfg_count - CSZ'(1);
          dwell_load_d = (cfg_dwell == '0) ? '0 : cfg_dwell - WSZ'(1);
`ifdef TUNER_SWEEP_LOOP_EN
          loop_d       = cfg_loop;
`else
          loop_d       = 1'b0;
`endif
          lo_freq_d    = cfg_start_freq;
          lo_dir_d     = cfg_dir;
          hop_idx_d    = '0;
          hop_strobe_d = 1'b1;
          busy_d       = 1'b1;
          tmr_load     = 1'b1;
          state_d      = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (tmr_zero) begin
          tmr_load     = 1'b1;
          tmr_load_val = dwell_load_q;
          iq_valid_d   = 1'b1;
          state_d      = S_DWELL;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      S_DWELL: begin
        if (!tmr_zero) begin
          tmr_dec    = 1'b1;
          iq_valid_d = 1'b1;
        end else if (hop_idx_q != last_idx_q) begin
          lo_freq_d    = lo_freq_q + step_q;
          hop_idx_d    = hop_idx_q + CSZ'(1);
          hop_strobe_d = 1'b1;
          state_d      = S_STEP;
        end else if (loop_q) begin
          lo_freq_d    = start_freq_q;
          hop_idx_d    = '0;
          hop_strobe_d = 1'b1;
          tmr_load     = 1'b1;
          state_d      = S_SETTLE;
        end else begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_STEP: begin
        tmr_load = 1'b1;
        state_d  = S_SETTLE;
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides everything outside IDLE but keeps the tuner where it is.
    if (abort && (state_q != S_IDLE)) begin
      state_d      = S_IDLE;
      lo_freq_d    = lo_freq_q;
      hop_idx_d    = hop_idx_q;
      busy_d       = 1'b0;
      done_d       = 1'b0;
      iq_valid_d   = 1'b0;
      hop_strobe_d = 1'b0;
      tmr_load     = 1'b0;
      tmr_dec      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      start_freq_q <= '0;
      step_q       <= '0;
      last_idx_q   <= '0;
      dwell_load_q <= '0;
      loop_q       <= 1'b0;
      lo_freq_q    <= '0;
      lo_dir_q     <= 1'b0;
      hop_idx_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      iq_valid_q   <= 1'b0;
      hop_strobe_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_freq_q <= start_freq_d;
      step_q       <= step_d;
      last_idx_q   <= last_idx_d;
      dwell_load_q <= dwell_load_d;
      loop_q       <= loop_d;
      lo_freq_q    <= lo_freq_d;
      lo_dir_q     <= lo_dir_d;
      hop_idx_q    <= hop_idx_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      iq_valid_q   <= iq_valid_d;
      hop_strobe_q <= hop_strobe_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign lo_freq    = lo_freq_q;
  assign lo_dir     = lo_dir_q;
  assign iq_valid   = iq_valid_q;
  assign hop_idx    = hop_idx_q;
  assign hop_strobe = hop_strobe_q;

endmodule

`default_nettype wire

// File: doc/tuner_sweep_ctrl.md
TUNER_SWEEP_CTRL -- requirements
Module: tuner_sweep_ctrl

Interface
REQ-001 SHALL have parameter FSZ, 31, NCO tuning word width.
REQ-002 SHALL have parameter CSZ, 16, hop-count width.
REQ-003 SHALL have parameter WSZ, 24, dwell-counter width.
REQ-004 SHALL have parameter SETTLE_CYC, 8, cycles of tuner pipeline settling after each retune (NCO + LO register + mixer).
REQ-005 SHALL have one clock and synchronous active-low reset:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-low.
REQ-006 SHALL have ports:
- start  in  1  begin sweep (sampled in IDLE only).
- abort  in  1  terminate sweep.
- cfg_start_freq  in  FSZ  first tuning word.
- cfg_step  in  FSZ  per-hop increment, two's complement.
- cfg_dir  in  1  LO direction for whole sweep.
- cfg_count  in  CSZ  number of hops.
- cfg_dwell  in  WSZ  valid cycles per hop.
- busy  out  1  sweep active.
- done  out  1  one-cycle pulse on normal completion.
- lo_freq  out  FSZ  tuning word to tuner.
- lo_dir  out  1  direction to tuner.
- iq_valid  out  1  tuner output settled and usable.
- hop_idx  out  CSZ  current hop index.
- hop_strobe  out  1  one-cycle pulse on every lo_freq load.

Function
REQ-007 SHALL implement FSM states IDLE, SETTLE, DWELL, STEP, DONE.
REQ-008 IDLE with start=1 SHALL latch all cfg_* and load lo_freq=cfg_start_freq, lo_dir=cfg_dir, hop_idx=0, and pulse hop_strobe; busy=1 from next cycle; next state SETTLE.
REQ-009 SETTLE SHALL last exactly SETTLE_CYC cycles with iq_valid=0, then go to DWELL.
REQ-010 DWELL SHALL last exactly max(cfg_dwell,1) cycles with iq_valid=1.
REQ-011 At DWELL end: if hop_idx == max(cfg_count,1)-1 go to DONE, else go to STEP.
REQ-012 STEP SHALL last one cycle: lo_freq += cfg_step modulo 2^FSZ (wrap, no saturation), hop_idx += 1, hop_strobe pulse, iq_valid=0; then SETTLE.
REQ-013 DONE SHALL last one cycle: done=1, busy=0 on exit; then IDLE; lo_freq/lo_dir/hop_idx hold last values.
REQ-014 cfg_* changes while busy SHALL have no effect on the current sweep.
REQ-015 start while busy SHALL be ignored.
REQ-016 abort=1 in any non-IDLE state SHALL force IDLE next cycle with iq_valid=0, busy=0, no done pulse; lo_freq holds.
REQ-017 start and abort both high in IDLE: abort wins; sweep not started.
REQ-018 iq_valid SHALL never be 1 in IDLE, SETTLE, STEP, or DONE.

Reset
REQ-019 reset=0 SHALL within one clock force IDLE, lo_freq=0, lo_dir=0, hop_idx=0, busy=0, done=0, iq_valid=0, hop_strobe=0, counters=0; mid-sweep reset behaves identically.

Configuration
REQ-020 With TUNER_SWEEP_LOOP_EN defined: input cfg_loop (1 bit, latched at start) SHALL exist; if 1, the final DWELL end reloads cfg_start_freq, sets hop_idx=0, pulses hop_strobe, enters SETTLE, and never pulses done (exit only via abort/reset).
REQ-021 Without TUNER_SWEEP_LOOP_EN: no cfg_loop port; sweep always terminates through DONE.

Structure
REQ-022 FSZ, DSZ, CSZ, WSZ defaults and the FSM state enum SHALL live in shared package tuner_pkg.
REQ-023 A single down-counter sub-module sweep_timer SHALL serve both SETTLE and DWELL (load value, decrement, zero flag).

Verification
REQ-024 start_freq=0x1000_0000, step=0x0100_0000, count=3, dwell=4, SETTLE_CYC=8 -> lo_freq 0x10000000/0x11000000/0x12000000, 3 hop_strobes, 12 iq_valid cycles, done after 3*(8+4)+2 cycles, busy then 0.
REQ-025 start_freq=0x7F00_0000, step=0x0200_0000, count=2 -> second lo_freq=0x0100_0000 (wrap).
REQ-026 count=0, dwell=0 -> exactly one hop, one iq_valid cycle, done pulse.
REQ-027 abort on 2nd DWELL cycle of hop 1 -> IDLE next cycle, iq_valid=0, no done; new start succeeds.
REQ-028 reset=0 during SETTLE -> all outputs 0 next cycle; start and abort together in IDLE -> busy stays 0.
REQ-029 With TUNER_SWEEP_LOOP_EN, cfg_loop=1, count=2 -> lo_freq sequence repeats start, start+step, start, ...; done never asserts.
